neuron_seq_fp: RTL and testbench



---
 rtl/neuron_seq_fp.sv | 216 +++++++++++++++++++++
 tb/tb_neuron_seq_fp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_fp.sv
// rtl/neuron_seq_fp.sv - time-multiplexed floating-point neuron with selectable activation
//
// Computes act(sum(w[i]*x[i]) + bias) over B = ceil(N_INPUTS/LANES) beats using
// LANES shared single-precision multipliers.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   input vector valid
//   in_ready    out  block idle and able to take a vector
//   input_in    in   N_INPUTS x 32-bit floats, input i at [i*32 +: 32]
//   out_valid   out  result held and valid
//   out_ready   in   downstream takes the result
//   output_out  out  activated result (float, or Q16 sigmoid word in mode 0)
//
// WEIGHTS packs N_INPUTS+1 floats, weight i at [i*32 +: 32]; index N_INPUTS is the bias.
module neuron_seq_fp #(
  parameter int                           N_INPUTS      = 37,
  parameter int                           LANES         = 8,
  parameter logic [(N_INPUTS+1)*32-1:0]   WEIGHTS       = '0,
  parameter int                           ACT_MODE      = 0,
  parameter int                           LUT_ADDR_BITS = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_INPUTS*32-1:0]  input_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             output_out
);

  localparam int B  = (N_INPUTS + LANES - 1) / LANES;
  localparam int NP = B * LANES;
  localparam int VW = NP * 32;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  // Padded lanes see +0.0 as both operand and weight.
  localparam logic [VW-1:0] W_PAD  = VW'(WEIGHTS[N_INPUTS*32-1:0]);
  localparam logic [31:0]   BIAS_W = WEIGHTS[N_INPUTS*32 +: 32];
  // Keeping only the top LUT_ADDR_BITS of the int16 code selects the LUT entry.
  localparam logic [15:0]   LUT_MASK = 16'hFFFF << (16 - LUT_ADDR_BITS);

  // Single-precision multiply, round-to-nearest-even, zero/denormal inputs flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        rnd;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m   = p[46:24];
      rnd = p[23] & ((|p[22:0]) | p[24]);
      e   = e + 10'd1;
    end else begin
      m   = p[45:23];
      rnd = p[22] & ((|p[21:0]) | p[23]);
    end
    if (e[9] || e == 10'd0) return {s, 31'd0};
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    // A rounding carry out of the mantissa correctly bumps the exponent.
    return {s, e[7:0], m} + 32'(rnd);
  endfunction

  // Single-precision add with truncating alignment; exact cancellation gives +0.0.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big;
    logic [31:0] sml;
    logic [24:0] r;
    logic [7:0]  e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    e = big[30:23];
    if (big[31] == sml[31])
      r = {2'b01, big[22:0]} + ({2'b01, sml[22:0]} >> (big[30:23] - sml[30:23]));
    else
      r = {2'b01, big[22:0]} - ({2'b01, sml[22:0]} >> (big[30:23] - sml[30:23]));
    if (r == 25'd0) return 32'd0;
    if (r[24]) return {big[31], e + 8'd1, r[23:1]};
    for (int i = 0; i < 24; i++) begin
      if (!r[23]) begin
        r = r << 1;
        e = e - 8'd1;
      end
    end
    return {big[31], e, r[22:0]};
  endfunction

  // Float to Q4.11 int16, truncating toward zero and saturating at +/-16.
  function automatic logic [15:0] f2i16(input logic [31:0] f);
    logic [15:0] mag;
    if (f[30:23] == 8'd0) return 16'd0;
    if (f[30:23] >= 8'd131) return f[31] ? 16'h8000 : 16'h7FFF;
    mag = 16'({1'b1, f[22:0]} >> (8'd139 - f[30:23]));
    return f[31] ? -mag : mag;
  endfunction

  // Piecewise-linear sigmoid of a Q4.11 code, returned as an unsigned Q16 word.
  function automatic logic [31:0] sigmoid_ip(input logic [15:0] c);
    logic [16:0] a;
    logic [16:0] y;
    a = c[15] ? (17'd0 - {1'b1, c}) : {1'b0, c};
    if (a >= 17'd10240)     y = 17'd65536;
    else if (a >= 17'd4864) y = a + 17'd55296;
    else if (a >= 17'd2048) y = (a << 2) + 17'd40960;
    else                    y = (a << 3) + 17'd32768;
    if (c[15]) y = 17'd65536 - y;
    return 32'(y);
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_CONV, S_LUT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic            alive_q;
  logic            bias_ph_q;
  logic            prod_vld_q;
  logic [BW-1:0]   beat_q;
  logic [VW-1:0]   x_q;
  logic [31:0]     prod_q [LANES];
  logic [31:0]     acc_q, sum_q, out_q;
  logic [15:0]     addr_q;
  logic [31:0]     tree_sum, acc_d, biased;

  assign output_out = out_q;

  always_comb begin
    tree_sum = prod_q[0];
    for (int l = 1; l < LANES; l++) tree_sum = fp_add(tree_sum, prod_q[l]);
    acc_d  = prod_vld_q ? fp_add(acc_q, tree_sum) : acc_q;
    biased = fp_add(acc_q, BIAS_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        // alive_q holds in_ready low until the first edge after reset release.
        in_ready = alive_q;
        if (in_valid && alive_q) state_d = S_MAC;
      end
      S_MAC:  if (beat_q == BW'(B - 1)) state_d = S_BIAS;
      // Phase 0 drains the last products into acc, phase 1 adds the bias.
      S_BIAS: if (bias_ph_q) state_d = (ACT_MODE == 0) ? S_CONV : S_HOLD;
      S_CONV: state_d = S_LUT;
      S_LUT:  state_d = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q    <= 1'b0;
      bias_ph_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      beat_q     <= '0;
      x_q        <= '0;
      for (int l = 0; l < LANES; l++) prod_q[l] <= 32'd0;
      acc_q      <= 32'd0;
      sum_q      <= 32'd0;
      out_q      <= 32'd0;
      addr_q     <= 16'd0;
    end else begin
      alive_q    <= 1'b1;
      prod_vld_q <= (state_q == S_MAC);
      acc_q      <= acc_d;
      case (state_q)
        S_IDLE: begin
          if (in_ready && in_valid) begin
            x_q       <= VW'(input_in);
            acc_q     <= 32'd0;
            beat_q    <= '0;
            bias_ph_q <= 1'b0;
          end
        end
        S_MAC: begin
          for (int l = 0; l < LANES; l++)
            prod_q[l] <= fp_mul(x_q[(int'(beat_q) * LANES + l) * 32 +: 32],
                                W_PAD[(int'(beat_q) * LANES + l) * 32 +: 32]);
          beat_q <= beat_q + BW'(1);
        end
        S_BIAS: begin
          bias_ph_q <= ~bias_ph_q;
          if (bias_ph_q) begin
            sum_q <= biased;
            if (ACT_MODE == 1)      out_q <= biased[31] ? 32'd0 : biased;
            else if (ACT_MODE == 2) out_q <= biased;
          end
        end
        S_CONV: addr_q <= f2i16(sum_q);
        S_LUT:  out_q  <= sigmoid_ip(addr_q & LUT_MASK);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_fp.sv
// tb/tb_neuron_seq_fp.sv - self-checking bench for neuron_seq_fp over four configurations
module tb_neuron_seq_fp;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [159:0]      xin = '0;
  logic [3:0]        rdy, vld;
  logic [3:0][31:0]  outs;
  int                n_cmp = 0;
  int                n_bad = 0;

  // Weights 1,2,3,4; instance 0/1 use bias 0.5, instance 3 bias 0.0.
  localparam logic [159:0] W4  = {32'h3F000000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [159:0] W4Z = {32'h00000000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [191:0] W5  = {32'h00000000, {5{32'h3F800000}}};

  typedef struct packed {
    logic [4:0][7:0]  x;
    logic [3:0][31:0] e;
    logic [7:0]       hold;
    logic             chain;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  neuron_seq_fp #(.N_INPUTS(4), .LANES(2), .WEIGHTS(W4), .ACT_MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .input_in(xin[127:0]),
    .out_valid(vld[0]), .out_ready(out_ready), .output_out(outs[0]));
  neuron_seq_fp #(.N_INPUTS(4), .LANES(2), .WEIGHTS(W4), .ACT_MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .input_in(xin[127:0]),
    .out_valid(vld[1]), .out_ready(out_ready), .output_out(outs[1]));
  neuron_seq_fp #(.N_INPUTS(5), .LANES(2), .WEIGHTS(W5), .ACT_MODE(2)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .input_in(xin),
    .out_valid(vld[2]), .out_ready(out_ready), .output_out(outs[2]));
  neuron_seq_fp #(.N_INPUTS(4), .LANES(2), .WEIGHTS(W4Z), .ACT_MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .input_in(xin[127:0]),
    .out_valid(vld[3]), .out_ready(out_ready), .output_out(outs[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // IEEE single encoding of a real that is exactly representable.
  function automatic logic [31:0] fbits(input real r);
    real    m;
    int     e;
    logic   s;
    longint fr;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr = longint'((m - 1.0) * 8388608.0);
    return {s, e[7:0], fr[22:0]};
  endfunction

  // Sigmoid word: x scaled to a saturated Q4.11 code, LUT keeps top 12 bits, PLAN curve in Q16.
  function automatic logic [31:0] sig_model(input int s);
    real code, cm, x, ax, y;
    longint yi;
    code = real'(s) * 2048.0;
    if (code > 32767.0)  code = 32767.0;
    if (code < -32768.0) code = -32768.0;
    cm = $floor(code / 16.0) * 16.0;
    x  = cm / 2048.0;
    ax = (x < 0.0) ? -x : x;
    if (ax >= 5.0)        y = 1.0;
    else if (ax >= 2.375) y = 0.03125 * ax + 0.84375;
    else if (ax >= 1.0)   y = 0.125 * ax + 0.625;
    else                  y = 0.25 * ax + 0.5;
    if (x < 0.0) y = 1.0 - y;
    yi = longint'(y * 65536.0);
    return yi[31:0];
  endfunction

  function automatic logic [3:0][31:0] model(input logic [4:0][7:0] x);
    int  s4, s5;
    real sb;
    logic [3:0][31:0] e;
    s4 = 0; s5 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) s4 += (i + 1) * int'($signed(x[i]));
      s5 += int'($signed(x[i]));
    end
    sb   = real'(s4) + 0.5;
    e[0] = fbits(sb);
    e[1] = (sb < 0.0) ? 32'h0 : fbits(sb);
    e[2] = fbits(real'(s5));
    e[3] = sig_model(s4);
    return e;
  endfunction

  task automatic add_row(input int a0, a1, a2, a3, a4,
                         input logic [31:0] e0, e1, e2, e3, input int hold, input bit chain);
    vec_t v;
    v.x     = {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.e     = {e3, e2, e1, e0};
    v.hold  = 8'(hold);
    v.chain = chain;
    tbl.push_back(v);
  endtask

  // Entered at a negedge with all instances idle; leaves at a negedge after the out handshake.
  task automatic txn(input logic [4:0][7:0] x, input logic [3:0][31:0] e, input int hold, input bit chain);
    int lat[4];
    bit done;
    for (int i = 0; i < 5; i++) xin[i*32 +: 32] = fbits(real'($signed(x[i])));
    in_valid = 1'b1;
    chk("accept_ready", 32'(rdy), 32'hF);
    @(negedge clk);
    in_valid = 1'b0;
    xin = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    chk("busy_flags", {24'h0, rdy, vld}, 32'h0);
    lat = '{-1, -1, -1, -1};
    done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (vld[i] && lat[i] < 0) lat[i] = k;
      done = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0) && (lat[3] >= 0);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("latency_%0d", i), 32'(lat[i]), (i == 3) ? 32'd6 : (i == 2) ? 32'd5 : 32'd4);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_flags", {24'h0, rdy, vld}, 32'h0F);
      for (int i = 0; i < 4; i++) chk($sformatf("hold_out_%0d", i), outs[i], e[i]);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("result_%0d", i), outs[i], e[i]);
    out_ready = 1'b1;
    in_valid  = chain;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {24'h0, rdy, vld}, 32'hF0);
  endtask

  initial begin
    vec_t v;
    add_row( 1,  1,  1,  1,  1, 32'h41280000, 32'h41280000, 32'h40A00000, 32'h00010000, 0, 1'b0);
    add_row(-1, -1, -1, -1, -1, 32'hC1180000, 32'h00000000, 32'hC0A00000, 32'h00000000, 0, 1'b1);
    add_row( 0,  0,  0,  0,  0, 32'h3F000000, 32'h3F000000, 32'h00000000, 32'h00008000, 2, 1'b0);
    add_row( 1,  2,  3,  4,  5, 32'h41F40000, 32'h41F40000, 32'h41700000, 32'h00010000, 0, 1'b1);
    add_row( 1,  0,  0, -1,  0, 32'hC0200000, 32'h00000000, 32'h00000000, 32'h00001000, 1, 1'b0);
    add_row( 0,  1,  0,  0,  0, 32'h40200000, 32'h40200000, 32'h3F800000, 32'h0000E000, 5, 1'b0);
    add_row( 1,  0,  0,  0,  0, 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h0000C000, 0, 1'b0);

    #1;
    chk("reset_ready", 32'(rdy), 32'h0);
    chk("reset_valid", 32'(vld), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_out_%0d", i), outs[i], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(rdy), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_flags", {24'h0, rdy, vld}, 32'hF0);
    end

    foreach (tbl[i]) txn(tbl[i].x, tbl[i].e, int'(tbl[i].hold), tbl[i].chain);
    in_valid = 1'b0;

    // Reset during MAC beat 1, then a fresh vector must come out clean.
    v = tbl[3];
    for (int i = 0; i < 5; i++) xin[i*32 +: 32] = fbits(real'($signed(v.x[i])));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(vld), 32'h0);
    chk("midrst_ready", 32'(rdy), 32'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_out_%0d", i), outs[i], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {24'h0, rdy, vld}, 32'hF0);
    txn(tbl[0].x, tbl[0].e, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      logic [4:0][7:0] x;
      for (int i = 0; i < 5; i++) x[i] = 8'(int'($urandom_range(6)) - 3);
      txn(x, model(x), int'($urandom_range(3)), r < 39 && ($urandom_range(1) == 1));
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
